// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return controller: owns the trap CSRs, flushes the pipeline and redirects fetch.
// Latency: outputs decode the registered state, so they appear 1 cycle after the trap or MRET edge; csr_rdata is combinational.
// Backpressure: busy holds the pipeline for the whole sequence; exceptions and MRET seen while busy are dropped.
module trap_ctrl #(
  parameter int unsigned        XLEN        = 64,
  parameter logic [XLEN-1:0]    MTVEC_RESET = '0,
  parameter logic [5:0]         NO_EXC      = 6'h1F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            busy,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    REDIR = 2'd2,
    RET   = 2'd3
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  // Clears the two low bits; used for word-aligned PCs and the mtvec base.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            mie;
  logic            mpie;

  logic            trap_take;
  logic            ret_take;
  logic            wr_mstatus;
  logic            wr_mtvec;
  logic            wr_mepc;
  logic            wr_mcause;
  logic            wr_mtval;

  // Events are only accepted in IDLE; an exception always beats a same-cycle MRET.
  assign trap_take = (state == IDLE) && (exc_code != NO_EXC);
  assign ret_take  = (state == IDLE) && mret && (exc_code == NO_EXC);

  assign wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign wr_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == ADDR_MEPC);
  assign wr_mcause  = csr_we && (csr_addr == ADDR_MCAUSE);
  assign wr_mtval   = csr_we && (csr_addr == ADDR_MTVAL);

  // State register; reset abandons any trap in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; every output is a function of state only.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        if (trap_take) begin
          state_nxt = TRAP;
        end else if (ret_take) begin
          state_nxt = RET;
        end
      end
      TRAP: begin
        busy      = 1'b1;
        flush     = 1'b1;
        state_nxt = REDIR;
      end
      REDIR: begin
        busy        = 1'b1;
        redirect    = 1'b1;
        // Vectored mode is not supported: always jump to the base.
        redirect_pc = mtvec & ALIGN_MASK;
        state_nxt   = IDLE;
      end
      RET: begin
        busy        = 1'b1;
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = mepc;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // mtvec is never touched by a trap, so software writes always land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtvec <= MTVEC_RESET;
    end else if (wr_mtvec) begin
      mtvec <= csr_wdata;
    end
  end

  // Trap capture takes priority over a software write in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
    end else if (trap_take) begin
      mepc   <= exc_pc & ALIGN_MASK;
      mcause <= {{(XLEN-6){1'b0}}, exc_code};
      mtval  <= exc_tval;
    end else begin
      if (wr_mepc) begin
        mepc <= csr_wdata & ALIGN_MASK;
      end
      if (wr_mcause) begin
        mcause <= csr_wdata;
      end
      if (wr_mtval) begin
        mtval <= csr_wdata;
      end
    end
  end

  // Interrupt-enable stack: trap pushes MIE into MPIE, MRET pops it back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie  <= 1'b0;
      mpie <= 1'b0;
    end else if (trap_take) begin
      mpie <= mie;
      mie  <= 1'b0;
    end else if (ret_take) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wr_mstatus) begin
      mie  <= csr_wdata[3];
      mpie <= csr_wdata[7];
    end
  end

  // CSR read mux; MPP is hardwired to machine mode.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mpie;
        csr_rdata[3]     = mie;
      end
      ADDR_MTVEC:  csr_rdata = mtvec;
      ADDR_MEPC:   csr_rdata = mepc;
      ADDR_MCAUSE: csr_rdata = mcause;
      ADDR_MTVAL:  csr_rdata = mtval;
      default:     csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam int unsigned XLEN    = 64;
  localparam logic [63:0] MTV_RST = 64'h0000_0000_0000_0200;
  localparam logic [5:0]  NO_EXC  = 6'h1F;

  logic            clk;
  logic            reset;
  logic [5:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            busy;
  logic            flush;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  trap_ctrl #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTV_RST),
    .NO_EXC      (NO_EXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_tval    (exc_tval),
    .mret        (mret),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .busy        (busy),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected values are queued when the stimulus is driven.
  task automatic expect_v(input string tag, input logic [63:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic check_v(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $display("FAIL %s: observed %h required %h", t, obs, e);
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a);
    csr_addr = a;
    #1;
    check_v(csr_rdata);
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic check_outs();
    check_v({63'd0, busy});
    check_v({63'd0, flush});
    check_v({63'd0, redirect});
    check_v(redirect_pc);
  endtask

  task automatic expect_outs(input string tag, input logic b, input logic f,
                             input logic r, input logic [63:0] pc);
    expect_v({tag, "_busy"}, {63'd0, b});
    expect_v({tag, "_flush"}, {63'd0, f});
    expect_v({tag, "_redirect"}, {63'd0, r});
    expect_v({tag, "_redirect_pc"}, pc);
  endtask

  initial begin
    int waited;
    bit seen;
    reset     = 1'b0;
    exc_code  = NO_EXC;
    exc_pc    = '0;
    exc_tval  = '0;
    mret      = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = 12'h000;
    csr_wdata = '0;

    // Reset state
    tick();
    tick();
    expect_outs("in_reset", 1'b0, 1'b0, 1'b0, 64'h0);
    check_outs();
    reset = 1'b1;
    tick();
    expect_v("rst_mtvec", MTV_RST);
    read_csr(12'h305);
    expect_v("rst_mepc", 64'h0);
    read_csr(12'h341);
    expect_v("rst_mcause", 64'h0);
    read_csr(12'h342);
    expect_v("rst_mstatus", 64'h1800);
    read_csr(12'h300);
    expect_v("unmapped_read", 64'h0);
    read_csr(12'h123);

    // Program mtvec and enable MIE
    write_csr(12'h305, 64'h8000_0101);
    expect_v("wr_mtvec", 64'h8000_0101);
    read_csr(12'h305);
    write_csr(12'h300, 64'h8);
    expect_v("wr_mstatus", 64'h1808);
    read_csr(12'h300);

    // Trap: cause 2, misaligned PC, tval DEAD
    exc_code = 6'd2;
    exc_pc   = 64'h1006;
    exc_tval = 64'hDEAD;
    expect_outs("trap_t1", 1'b1, 1'b1, 1'b0, 64'h0);
    expect_outs("trap_t2", 1'b1, 1'b0, 1'b1, 64'h8000_0100);
    expect_outs("trap_idle", 1'b0, 1'b0, 1'b0, 64'h0);
    expect_v("trap_mepc", 64'h1004);
    expect_v("trap_mcause", 64'h2);
    expect_v("trap_mtval", 64'hDEAD);
    expect_v("trap_mstatus", 64'h1880);
    tick();
    exc_code = 6'd5;          // arrives while busy: must be ignored
    exc_pc   = 64'h5550;
    exc_tval = 64'h5555;
    check_outs();
    tick();
    check_outs();
    tick();
    exc_code = NO_EXC;
    check_outs();
    read_csr(12'h341);
    read_csr(12'h342);
    read_csr(12'h343);
    read_csr(12'h300);

    // MRET: bounded wait for redirect, expected one cycle after the edge
    mret = 1'b1;
    expect_v("mret_latency", 64'd1);
    expect_outs("mret_ret", 1'b1, 1'b1, 1'b1, 64'h1004);
    expect_outs("mret_idle", 1'b0, 1'b0, 1'b0, 64'h0);
    expect_v("mret_mstatus", 64'h1888);
    waited = 0;
    seen   = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      mret = 1'b0;
      waited++;
      if (redirect) seen = 1'b1;
    end
    check_v(seen ? 64'(waited) : 64'hFFFF);
    check_outs();
    tick();
    check_outs();
    read_csr(12'h300);

    // Exception + MRET + CSR writes in the same cycle
    exc_code  = 6'hB;
    exc_pc    = 64'h2000;
    exc_tval  = 64'h0;
    mret      = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'h342;
    csr_wdata = 64'h55;
    expect_outs("exc_mret_t1", 1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    exc_code = NO_EXC;
    mret     = 1'b0;
    csr_addr = 12'h305;
    csr_wdata = 64'h4000;     // mtvec write while in TRAP lands
    check_outs();
    tick();
    csr_we = 1'b0;
    expect_outs("exc_mret_t2", 1'b1, 1'b0, 1'b1, 64'h4000);
    check_outs();
    tick();
    expect_v("exc_mret_mcause", 64'hB);
    read_csr(12'h342);
    expect_v("exc_mret_mepc", 64'h2000);
    read_csr(12'h341);
    expect_v("exc_mret_mstatus", 64'h1880);
    read_csr(12'h300);

    // Reset asserted while in REDIR
    exc_code = 6'd3;
    exc_pc   = 64'h3000;
    tick();
    exc_code = NO_EXC;
    tick();                   // now in REDIR
    reset = 1'b0;
    #1;
    expect_outs("rst_redir", 1'b0, 1'b0, 1'b0, 64'h0);
    check_outs();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (redirect) seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (redirect || busy) seen = 1'b1;
    end
    expect_v("rst_redir_never_redirect", 64'h0);
    check_v({63'd0, seen});
    expect_v("rst_redir_mepc", 64'h0);
    read_csr(12'h341);
    expect_v("rst_redir_mtvec", MTV_RST);
    read_csr(12'h305);

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
